// File: rtl/jtag_master.sv
// jtag_master: host-side IEEE 1149.1 scan driver.
//
// Each accepted command runs one complete IR or DR scan of 1..DATA_WIDTH
// bits. The scan starts in Run-Test/Idle and returns there. The TDO bits
// captured during the shift phase come back as a response.
//
// Ports:
//   CLK, RST             system clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY  command handshake (READY only while idle in RTI)
//   CMD_IR               1 = IR scan, 0 = DR scan
//   CMD_LEN              scan length in bits (clamped to DATA_WIDTH, 0 = no scan)
//   CMD_DATA             TDI bits, bit 0 shifted first
//   RSP_VALID            one-CLK pulse at scan completion
//   RSP_DATA             captured TDO bits, held until the next response
//   TCK, TMS, TDI, TDO   JTAG pins
//   STATE                tracked TAP state (only with JTAG_MASTER_STATUS_EN)
//
// Optional feature: define JTAG_MASTER_STATUS_EN to add the STATE output.
// STATE is the tracked TAP state. Its codes match the jtag TAP:
// TLR=0, RTI=F, SEL_DR=E, CAP_DR=D, SHIFT_DR=C, EXIT1_DR=B, UPD_DR=8,
// SEL_IR=7, CAP_IR=6, SHIFT_IR=5, EXIT1_IR=4, UPD_IR=1.
module jtag_master #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 6,
    parameter int TCK_HALF   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_IR,
    input  logic [LEN_W-1:0]      CMD_LEN,
    input  logic [DATA_WIDTH-1:0] CMD_DATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  TCK,
    output logic                  TMS,
    output logic                  TDI,
    input  logic                  TDO
`ifdef JTAG_MASTER_STATUS_EN
    ,
    output logic [3:0]            STATE
`endif
);

    localparam int               DIV_W    = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_HALF - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_SYNC, S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE
    } state_t;

    state_t                  state, state_next, nxt_phase;
    logic [DIV_W-1:0]        div_cnt;
    logic                    tck_q, tms_q, tdi_q, ir_q;
    logic [LEN_W-1:0]        edge_cnt, len_q, len_in, phase_len, nxt_idx;
    logic [DATA_WIDTH-1:0]   data_q, cap_q, rsp_q;
    logic                    running, half_done, tck_rise, tck_fall, accept;
    logic                    phase_end, tms_sel, tdi_sel;

    assign running   = state inside {S_SYNC, S_PRE, S_SHIFT, S_POST};
    assign half_done = (div_cnt == DIV_LAST);
    assign tck_rise  = running && !tck_q && half_done;
    assign tck_fall  = running &&  tck_q && half_done;
    assign accept    = CMD_VALID && (state == S_IDLE);
    assign len_in    = (CMD_LEN > LEN_MAX) ? LEN_MAX : CMD_LEN;

    // Phase changes happen on the TCK fall after a phase's last rising
    // edge. TCK is therefore always low when a phase begins or the scan ends.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_next = state;
        phase_len  = '0;
        tms_sel    = 1'b0;
        tdi_sel    = 1'b0;
        case (state)
            S_SYNC:  phase_len = LEN_W'(6);
            S_PRE:   phase_len = ir_q ? LEN_W'(4) : LEN_W'(3);
            S_SHIFT: phase_len = len_q;
            S_POST:  phase_len = LEN_W'(2);
            default: ;
        endcase
        phase_end = tck_fall && (edge_cnt == phase_len);

        case (state)
            S_SYNC:  if (phase_end) state_next = S_IDLE;
            S_IDLE:  if (CMD_VALID) state_next = (len_in == '0) ? S_DONE : S_PRE;
            S_PRE:   if (phase_end) state_next = S_SHIFT;
            S_SHIFT: if (phase_end) state_next = S_POST;
            S_POST:  if (phase_end) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_SYNC;
        endcase

        // TMS/TDI for the next rising edge, loaded at the current fall.
        nxt_phase = phase_end ? state_next : state;
        nxt_idx   = phase_end ? '0 : edge_cnt;
        case (nxt_phase)
            S_SYNC:  tms_sel = (nxt_idx < LEN_W'(5));
            S_PRE:   tms_sel = ir_q ? (nxt_idx < LEN_W'(2)) : (nxt_idx == '0);
            S_SHIFT: begin
                tms_sel = (nxt_idx == len_q - LEN_W'(1));
                tdi_sel = |(data_q & (DATA_WIDTH'(1) << nxt_idx));
            end
            S_POST:  tms_sel = (nxt_idx == '0);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_SYNC;
            div_cnt  <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            edge_cnt <= '0;
            ir_q     <= 1'b0;
            len_q    <= '0;
            data_q   <= '0;
            cap_q    <= '0;
            rsp_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state <= state_next;

            if (running) div_cnt <= half_done ? '0 : div_cnt + 1'b1;
            else         div_cnt <= '0;

            if (tck_rise) begin
                tck_q    <= 1'b1;
                edge_cnt <= edge_cnt + 1'b1;
                if (state == S_SHIFT)
                    cap_q <= cap_q | (DATA_WIDTH'(TDO) << edge_cnt);
            end

            if (tck_fall) begin
                tck_q <= 1'b0;
                tms_q <= tms_sel;
                tdi_q <= tdi_sel;
                if (phase_end) edge_cnt <= '0;
            end

            // The scan starts with TCK low. The first header bit (TMS=1)
            // goes out at once.
            if (accept) begin
                ir_q     <= CMD_IR;
                len_q    <= len_in;
                data_q   <= CMD_DATA;
                cap_q    <= '0;
                tms_q    <= 1'b1;
                tdi_q    <= 1'b0;
                edge_cnt <= '0;
                if (len_in == '0) rsp_q <= '0;
            end

            if (state == S_POST && phase_end) rsp_q <= cap_q;
        end
    end

    assign CMD_READY = (state == S_IDLE);
    assign RSP_VALID = (state == S_DONE);
    assign RSP_DATA  = rsp_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

`ifdef JTAG_MASTER_STATUS_EN
    localparam logic [3:0] T_TLR = 4'h0, T_RTI = 4'hF, T_SEL_DR = 4'hE,
                           T_CAP_DR = 4'hD, T_SHIFT_DR = 4'hC, T_EXIT1_DR = 4'hB,
                           T_PAUSE_DR = 4'hA, T_EXIT2_DR = 4'h9, T_UPD_DR = 4'h8,
                           T_SEL_IR = 4'h7, T_CAP_IR = 4'h6, T_SHIFT_IR = 4'h5,
                           T_EXIT1_IR = 4'h4, T_PAUSE_IR = 4'h3, T_EXIT2_IR = 4'h2,
                           T_UPD_IR = 4'h1;

    logic [3:0] tap_q, tap_next;

    always_comb begin
        tap_next = tap_q;
        case (tap_q)
            T_TLR:      tap_next = tms_q ? T_TLR      : T_RTI;
            T_RTI:      tap_next = tms_q ? T_SEL_DR   : T_RTI;
            T_SEL_DR:   tap_next = tms_q ? T_SEL_IR   : T_CAP_DR;
            T_CAP_DR:   tap_next = tms_q ? T_EXIT1_DR : T_SHIFT_DR;
            T_SHIFT_DR: tap_next = tms_q ? T_EXIT1_DR : T_SHIFT_DR;
            T_EXIT1_DR: tap_next = tms_q ? T_UPD_DR   : T_PAUSE_DR;
            T_PAUSE_DR: tap_next = tms_q ? T_EXIT2_DR : T_PAUSE_DR;
            T_EXIT2_DR: tap_next = tms_q ? T_UPD_DR   : T_SHIFT_DR;
            T_UPD_DR:   tap_next = tms_q ? T_SEL_DR   : T_RTI;
            T_SEL_IR:   tap_next = tms_q ? T_TLR      : T_CAP_IR;
            T_CAP_IR:   tap_next = tms_q ? T_EXIT1_IR : T_SHIFT_IR;
            T_SHIFT_IR: tap_next = tms_q ? T_EXIT1_IR : T_SHIFT_IR;
            T_EXIT1_IR: tap_next = tms_q ? T_UPD_IR   : T_PAUSE_IR;
            T_PAUSE_IR: tap_next = tms_q ? T_EXIT2_IR : T_PAUSE_IR;
            T_EXIT2_IR: tap_next = tms_q ? T_UPD_IR   : T_SHIFT_IR;
            T_UPD_IR:   tap_next = tms_q ? T_SEL_DR   : T_RTI;
            default:    tap_next = T_TLR;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)           tap_q <= T_TLR;
        else if (tck_rise) tap_q <= tap_next;
    end

    assign STATE = tap_q;
`endif

endmodule
